// File: rtl/univ_shift_reg_pkg.sv
// Shared types for the universal shift register: per-cycle modes, burst ops, FSM states.
// Imported by the burst controller and the top-level datapath.
package usr_pkg;

  typedef enum logic [2:0] {
    HOLD = 3'b000,
    LOAD = 3'b001,
    SHL  = 3'b010,
    SHR  = 3'b011,
    ROTL = 3'b100,
    ROTR = 3'b101
  } usr_mode_t;

  typedef enum logic [1:0] {
    B_SHL  = 2'b00,
    B_SHR  = 2'b01,
    B_ROTL = 2'b10,
    B_ROTR = 2'b11
  } usr_burst_op_t;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

endpackage

// File: rtl/univ_shift_reg_if.sv
// Control/data bundle for univ_shift_reg; master drives operations, slave is the register.
// The parity signal exists only when USR_PARITY_EN is defined.
interface univ_shift_reg_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH) + 1
);
  logic [2:0]       mode;
  logic [WIDTH-1:0] D;
  logic             sin_l;
  logic             sin_r;
  logic             start;
  logic [AMT_W-1:0] amt;
  logic [1:0]       burst_op;
  logic [WIDTH-1:0] Q;
  logic             sout_l;
  logic             sout_r;
  logic             busy;
  logic             done;
`ifdef USR_PARITY_EN
  logic             parity;

  modport master (
    output mode, D, sin_l, sin_r, start, amt, burst_op,
    input  Q, sout_l, sout_r, busy, done, parity
  );
  modport slave (
    input  mode, D, sin_l, sin_r, start, amt, burst_op,
    output Q, sout_l, sout_r, busy, done, parity
  );
`else
  modport master (
    output mode, D, sin_l, sin_r, start, amt, burst_op,
    input  Q, sout_l, sout_r, busy, done
  );
  modport slave (
    input  mode, D, sin_l, sin_r, start, amt, burst_op,
    output Q, sout_l, sout_r, busy, done
  );
`endif
endinterface

// File: rtl/usr_burst_ctrl.sv
// Burst sequencer: counts amt back-to-back shift cycles from one start pulse, then pulses done.
// busy/done are registered; shift_en/mode_en are decoded from the current state for the datapath.
module usr_burst_ctrl
  import usr_pkg::*;
#(
  parameter int AMT_W = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AMT_W-1:0] amt,
  input  usr_burst_op_t burst_op,
  output logic          shift_en,
  output logic          mode_en,
  output usr_burst_op_t op,
  output logic          busy,
  output logic          done
);

  state_t           state;
  logic [AMT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      op    <= B_SHL;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (amt != '0) begin
              cnt   <= amt;
              op    <= burst_op;
              state <= BURST;
              busy  <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        BURST: begin
          cnt <= cnt - AMT_W'(1);
          // Last shift happens on this edge, so busy drops and done rises together.
          if (cnt == AMT_W'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign shift_en = (state == BURST);
  assign mode_en  = (state == IDLE) && !start;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit register: hold/load/shift/rotate per cycle plus an N-shift burst engine.
// Define USR_PARITY_EN to add a registered even-parity output tracking ^Q.
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               AMT_W     = $clog2(WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  univ_shift_reg_if.slave       bus
);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_nxt;
  logic             shift_en;
  logic             mode_en;
  usr_burst_op_t    op;
  logic             busy;
  logic             done;

  usr_burst_ctrl #(.AMT_W(AMT_W)) u_ctrl (
    .clk      (clk),
    .reset    (reset),
    .start    (bus.start),
    .amt      (bus.amt),
    .burst_op (usr_burst_op_t'(bus.burst_op)),
    .shift_en (shift_en),
    .mode_en  (mode_en),
    .op       (op),
    .busy     (busy),
    .done     (done)
  );

  // Burst shifts take priority; mode only acts when idle with no start pending.
  always_comb begin
    q_nxt = q;
    if (shift_en) begin
      case (op)
        B_SHL:   q_nxt = {q[WIDTH-2:0], bus.sin_l};
        B_SHR:   q_nxt = {bus.sin_r, q[WIDTH-1:1]};
        B_ROTL:  q_nxt = {q[WIDTH-2:0], q[WIDTH-1]};
        B_ROTR:  q_nxt = {q[0], q[WIDTH-1:1]};
        default: q_nxt = q;
      endcase
    end else if (mode_en) begin
      case (usr_mode_t'(bus.mode))
        LOAD:    q_nxt = bus.D;
        SHL:     q_nxt = {q[WIDTH-2:0], bus.sin_l};
        SHR:     q_nxt = {bus.sin_r, q[WIDTH-1:1]};
        ROTL:    q_nxt = {q[WIDTH-2:0], q[WIDTH-1]};
        ROTR:    q_nxt = {q[0], q[WIDTH-1:1]};
        default: q_nxt = q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) q <= RESET_VAL;
    else       q <= q_nxt;
  end

`ifdef USR_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk) begin
    if (reset) parity_q <= ^RESET_VAL;
    else       parity_q <= ^q_nxt;
  end

  assign bus.parity = parity_q;
`endif

  assign bus.Q      = q;
  assign bus.sout_l = q[WIDTH-1];
  assign bus.sout_r = q[0];
  assign bus.busy   = busy;
  assign bus.done   = done;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (WIDTH=8, RESET_VAL=0): modes, bursts, reset mid-burst.
// Parity checks are compiled in when USR_PARITY_EN is defined.
module tb_univ_shift_reg;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  univ_shift_reg_if #(.WIDTH(8), .AMT_W(4)) bus ();

  univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00), .AMT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    reset        = 1'b1;
    bus.mode     = 3'b000;
    bus.D        = 8'h00;
    bus.sin_l    = 1'b0;
    bus.sin_r    = 1'b0;
    bus.start    = 1'b0;
    bus.amt      = 4'd0;
    bus.burst_op = 2'b00;
    tick();
    chk8("reset_q", bus.Q, 8'h00);
    chk1("reset_busy", bus.busy, 1'b0);
    chk1("reset_done", bus.done, 1'b0);
`ifdef USR_PARITY_EN
    chk1("reset_parity", bus.parity, 1'b0);
`endif
    reset = 1'b0;

    // Load and hold
    bus.mode = 3'b001; bus.D = 8'hA5;
    tick();
    chk8("load_a5", bus.Q, 8'hA5);
    bus.mode = 3'b000;
    tick(); tick(); tick();
    chk8("hold_3", bus.Q, 8'hA5);

    // Single-cycle shifts and serial taps
    bus.mode = 3'b010; bus.sin_l = 1'b1;
    tick();
    chk8("shl_1", bus.Q, 8'h4B);
    chk1("shl_sout_l", bus.sout_l, 1'b0);
    chk1("shl_sout_r", bus.sout_r, 1'b1);
    bus.mode = 3'b101;
    tick();
    chk8("rotr", bus.Q, 8'hA5);
    chk1("rotr_sout_l", bus.sout_l, 1'b1);
    bus.mode = 3'b011; bus.sin_r = 1'b0;
    tick();
    chk8("shr_0", bus.Q, 8'h52);
    chk1("shr_sout_r", bus.sout_r, 1'b0);
    bus.mode = 3'b110;
    tick();
    chk8("mode_110_hold", bus.Q, 8'h52);

    // Burst rotl by 3 on 0x81, with load requested throughout
    bus.mode = 3'b001; bus.D = 8'h81;
    tick();
    bus.D = 8'h00;
    bus.start = 1'b1; bus.amt = 4'd3; bus.burst_op = 2'b10;
    tick();
    bus.start = 1'b0;
    chk8("rotl3_e0_q", bus.Q, 8'h81);
    chk1("rotl3_e0_busy", bus.busy, 1'b1);
    chk1("rotl3_e0_done", bus.done, 1'b0);
    tick();
    chk8("rotl3_e1_q", bus.Q, 8'h03);
    chk1("rotl3_e1_busy", bus.busy, 1'b1);
    tick();
    chk8("rotl3_e2_q", bus.Q, 8'h06);
    chk1("rotl3_e2_done", bus.done, 1'b0);
    tick();
    chk8("rotl3_e3_q", bus.Q, 8'h0C);
    chk1("rotl3_e3_busy", bus.busy, 1'b0);
    chk1("rotl3_e3_done", bus.done, 1'b1);
    bus.mode = 3'b000;
    tick();
    chk1("rotl3_done_once", bus.done, 1'b0);
    chk8("rotl3_after", bus.Q, 8'h0C);

    // amt=0: immediate done, no busy
    bus.start = 1'b1; bus.amt = 4'd0;
    tick();
    bus.start = 1'b0;
    chk1("amt0_done", bus.done, 1'b1);
    chk1("amt0_busy", bus.busy, 1'b0);
    chk8("amt0_q", bus.Q, 8'h0C);
    tick();
    chk1("amt0_done_clr", bus.done, 1'b0);

    // amt=9 rotl on 0x01 wraps to 0x02; a start mid-burst is ignored
    bus.mode = 3'b001; bus.D = 8'h01;
    tick();
    bus.mode = 3'b000;
    bus.start = 1'b1; bus.amt = 4'd9; bus.burst_op = 2'b10;
    tick();
    bus.start = 1'b0;
    tick(); tick();
    bus.start = 1'b1; bus.amt = 4'd1; bus.burst_op = 2'b00; bus.sin_l = 1'b0;
    tick();
    bus.start = 1'b0;
    chk8("rotl9_mid_q", bus.Q, 8'h08);
    tick(); tick(); tick(); tick(); tick();
    chk1("rotl9_e8_busy", bus.busy, 1'b1);
    chk8("rotl9_e8_q", bus.Q, 8'h01);
    tick();
    chk8("rotl9_q", bus.Q, 8'h02);
    chk1("rotl9_done", bus.done, 1'b1);
    chk1("rotl9_busy", bus.busy, 1'b0);

    // Reset mid-burst, then a fresh burst still works
    bus.start = 1'b1; bus.amt = 4'd5; bus.burst_op = 2'b00; bus.sin_l = 1'b0;
    tick();
    bus.start = 1'b0;
    tick();
    chk8("rst_mid_q1", bus.Q, 8'h04);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk8("rst_mid_q", bus.Q, 8'h00);
    chk1("rst_mid_busy", bus.busy, 1'b0);
    chk1("rst_mid_done", bus.done, 1'b0);
    tick();
    chk1("rst_mid_done_a", bus.done, 1'b0);
    tick();
    chk1("rst_mid_done_b", bus.done, 1'b0);
    bus.start = 1'b1; bus.amt = 4'd1; bus.burst_op = 2'b01; bus.sin_r = 1'b1;
    tick();
    bus.start = 1'b0;
    chk1("post_rst_busy", bus.busy, 1'b1);
    tick();
    chk8("post_rst_q", bus.Q, 8'h80);
    chk1("post_rst_done", bus.done, 1'b1);
    bus.mode = 3'b100;
    tick();
    chk8("rotl_mode", bus.Q, 8'h01);

`ifdef USR_PARITY_EN
    bus.mode = 3'b001; bus.D = 8'h07;
    tick();
    chk1("par_07", bus.parity, 1'b1);
    bus.mode = 3'b010; bus.sin_l = 1'b0;
    tick();
    chk8("par_shl_q", bus.Q, 8'h0E);
    chk1("par_0e", bus.parity, 1'b1);
    bus.mode = 3'b001; bus.D = 8'h03;
    tick();
    chk1("par_03", bus.parity, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
